// File: rtl/uart_tx_scheduler_if.sv
// Requester / encoder / transmitter signal bundle around the shared UART TX scheduler.
// master: the scheduler side; slave: the requesters plus encoder and transmitter.
interface uart_tx_scheduler_if #(
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ-1:0]      req_ready;
  logic [NUM_REQ-1:0][3:0] req_data;
  logic                    enc_ena;
  logic [3:0]              enc_data;
  logic [6:0]              enc_code;
  logic                    enc_valid;
  logic                    tx_start;
  logic [7:0]              tx_data;
  logic                    tx_busy;

  modport master (
    input  req_valid, req_data, enc_code, enc_valid, tx_busy,
    output req_ready, enc_ena, enc_data, tx_start, tx_data
  );

  modport slave (
    output req_valid, req_data, enc_code, enc_valid, tx_busy,
    input  req_ready, enc_ena, enc_data, tx_start, tx_data
  );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Round-robin arbiter that shares one Hamming(7,4) encoder and one UART transmitter
// between NUM_REQ nibble requesters: grant, encode, launch frame, wait for completion.
module uart_tx_scheduler #(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic                err_clr,
  uart_tx_scheduler_if.master bus,
  output logic [1:0]          active_id,
  output logic                sched_busy,
  output logic                timeout_err,
  output logic [7:0]          frame_count
);

  typedef enum logic [2:0] {
    IDLE, ENCODE, WAIT_ENC, LAUNCH, WAIT_BUSY, WAIT_DONE
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t             state;
  logic [1:0]         last_grant;
  logic [7:0]         tmo_cnt;

  logic               win_found;
  logic [1:0]         win_id;
  logic [3:0]         win_data;
  logic [NUM_REQ-1:0] win_oh;
  logic               grant;

  // Search upward from the requester after the last grant, wrapping at NUM_REQ.
  always_comb begin
    int idx;
    idx       = 0;
    win_found = 1'b0;
    win_id    = '0;
    win_data  = '0;
    win_oh    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_grant) + k) % NUM_REQ;
      if (!win_found && bus.req_valid[idx]) begin
        win_found   = 1'b1;
        win_id      = 2'(idx);
        win_data    = bus.req_data[idx];
        win_oh[idx] = 1'b1;
      end
    end
  end

  assign grant         = (state == IDLE) && ena && !bus.tx_busy && win_found;
  assign bus.req_ready = grant ? win_oh : '0;
  assign sched_busy    = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      last_grant   <= 2'(NUM_REQ - 1);
      tmo_cnt      <= '0;
      active_id    <= '0;
      timeout_err  <= 1'b0;
      frame_count  <= '0;
      bus.enc_ena  <= 1'b0;
      bus.enc_data <= '0;
      bus.tx_start <= 1'b0;
      bus.tx_data  <= '0;
    end else begin
      bus.enc_ena  <= 1'b0;
      bus.tx_start <= 1'b0;
      // A timeout set later in this block overrides a same-cycle clear.
      if (err_clr) timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (grant) begin
            bus.enc_data <= win_data;
            active_id    <= win_id;
            last_grant   <= win_id;
            bus.enc_ena  <= 1'b1;
            state        <= ENCODE;
          end
        end
        ENCODE: begin
          tmo_cnt <= '0;
          state   <= WAIT_ENC;
        end
        WAIT_ENC: begin
          if (bus.enc_valid) begin
            // tx_data[6:0] doubles as the captured codeword register.
            bus.tx_data  <= {1'b0, bus.enc_code};
            bus.tx_start <= 1'b1;
            state        <= LAUNCH;
          end else if (tmo_cnt == TMO_LAST) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        LAUNCH: begin
          tmo_cnt <= '0;
          state   <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (bus.tx_busy) begin
            state <= WAIT_DONE;
          end else if (tmo_cnt == TMO_LAST) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        WAIT_DONE: begin
          if (!bus.tx_busy) begin
            frame_count <= frame_count + 8'd1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: basic transfer, round-robin, timeout,
// grant gating, reset mid-frame and frame counter wrap.
module tb_uart_tx_scheduler;
  localparam int NUM_REQ = 2;
  localparam int TIMEOUT = 15;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       err_clr;
  logic [1:0] active_id;
  logic       sched_busy;
  logic       timeout_err;
  logic [7:0] frame_count;

  int         checks = 0;
  int         errors = 0;
  int         tx_start_cnt = 0;
  int         tx_snap;
  logic [7:0] exp_fc;

  uart_tx_scheduler_if #(.NUM_REQ(NUM_REQ)) bus ();

  uart_tx_scheduler #(.NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .err_clr     (err_clr),
    .bus         (bus),
    .active_id   (active_id),
    .sched_busy  (sched_busy),
    .timeout_err (timeout_err),
    .frame_count (frame_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (bus.tx_start === 1'b1) tx_start_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full transfer starting in IDLE with requests already driven; encoder answers
  // two cycles after enc_ena, transmitter busy for three cycles.
  task automatic xfer(input int id, input logic [3:0] nib, input logic [6:0] code);
    logic [1:0] oh;
    oh = 2'b01 << id;
    #1;
    chk("grant_ready", bus.req_ready, oh);
    tick();
    chk("enc_ena_pulse", bus.enc_ena, 1);
    chk("enc_data", bus.enc_data, nib);
    chk("active_id", active_id, id);
    chk("ready_busy", bus.req_ready, 0);
    tick();
    chk("enc_ena_drop", bus.enc_ena, 0);
    tick();
    bus.enc_valid = 1'b1;
    bus.enc_code  = code;
    tick();
    bus.enc_valid = 1'b0;
    chk("tx_start_pulse", bus.tx_start, 1);
    chk("tx_data", bus.tx_data, {1'b0, code});
    tick();
    bus.tx_busy = 1'b1;
    chk("tx_start_drop", bus.tx_start, 0);
    tick();
    tick();
    tick();
    chk("busy_in_done", sched_busy, 1);
    bus.tx_busy = 1'b0;
    tick();
    exp_fc++;
    chk("frame_count", frame_count, exp_fc);
    chk("idle_after", sched_busy, 0);
  endtask

  task automatic fast_frame();
    bus.req_valid = 2'b01;
    tick();
    bus.req_valid = 2'b00;
    tick();
    bus.enc_valid = 1'b1;
    tick();
    bus.enc_valid = 1'b0;
    tick();
    bus.tx_busy = 1'b1;
    tick();
    bus.tx_busy = 1'b0;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; err_clr = 1'b0;
    bus.req_valid = '0; bus.req_data = '0;
    bus.enc_code = '0; bus.enc_valid = 1'b0; bus.tx_busy = 1'b0;
    exp_fc = 8'd0;
    #12;
    chk("rst_enc_ena", bus.enc_ena, 0);
    chk("rst_tx_start", bus.tx_start, 0);
    chk("rst_tx_data", bus.tx_data, 0);
    chk("rst_frame_count", frame_count, 0);
    rst_n = 1'b1;
    tick();

    // Basic transfer
    bus.req_data  = {4'h0, 4'hB};
    bus.req_valid = 2'b01;
    xfer(0, 4'hB, 7'h55);
    bus.req_valid = 2'b00;

    // Round-robin from reset: 0,1,0,1
    rst_n = 1'b0; #2; rst_n = 1'b1; exp_fc = 8'd0;
    tick();
    bus.req_data  = {4'hC, 4'h3};
    bus.req_valid = 2'b11;
    xfer(0, 4'h3, 7'h33);
    xfer(1, 4'hC, 7'h4C);
    xfer(0, 4'h3, 7'h33);
    xfer(1, 4'hC, 7'h4C);
    bus.req_valid = 2'b00;

    // Encoder timeout
    tx_snap = tx_start_cnt;
    bus.req_data  = {4'h0, 4'h5};
    bus.req_valid = 2'b01;
    #1;
    chk("tmo_ready", bus.req_ready, 2'b01);
    tick();
    bus.req_valid = 2'b00;
    tick();
    repeat (TIMEOUT - 1) tick();
    chk("tmo_still_wait", sched_busy, 1);
    chk("tmo_err_early", timeout_err, 0);
    tick();
    chk("tmo_idle", sched_busy, 0);
    chk("tmo_err_set", timeout_err, 1);
    chk("tmo_no_tx_start", tx_start_cnt, tx_snap);
    chk("tmo_fc_same", frame_count, exp_fc);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("err_clr", timeout_err, 0);

    // Grant gating
    ena = 1'b0;
    bus.req_data  = {4'h0, 4'h9};
    bus.req_valid = 2'b01;
    #1;
    chk("gate_ena_ready", bus.req_ready, 0);
    tick();
    chk("gate_ena_idle", sched_busy, 0);
    ena = 1'b1;
    bus.tx_busy = 1'b1;
    #1;
    chk("gate_busy_ready", bus.req_ready, 0);
    tick();
    chk("gate_busy_idle", sched_busy, 0);
    bus.tx_busy = 1'b0;
    xfer(0, 4'h9, 7'h2A);
    bus.req_data = {4'h0, 4'h6};
    xfer(0, 4'h6, 7'h11);
    bus.req_valid = 2'b00;

    // Reset in WAIT_DONE, with ena dropped mid-transfer
    bus.req_data  = {4'hA, 4'h1};
    bus.req_valid = 2'b10;
    #1;
    chk("rstd_ready", bus.req_ready, 2'b10);
    tick();
    ena = 1'b0;
    bus.req_valid = 2'b00;
    tick();
    tick();
    bus.enc_valid = 1'b1;
    bus.enc_code  = 7'h7F;
    tick();
    bus.enc_valid = 1'b0;
    chk("ena_low_launch", bus.tx_start, 1);
    tick();
    bus.tx_busy = 1'b1;
    tick();
    chk("rstd_in_done", sched_busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstd_busy", sched_busy, 0);
    chk("rstd_active_id", active_id, 0);
    chk("rstd_tx_data", bus.tx_data, 0);
    chk("rstd_enc_data", bus.enc_data, 0);
    chk("rstd_fc", frame_count, 0);
    tx_snap = tx_start_cnt;
    bus.tx_busy = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_fc = 8'd0;
    tick();
    chk("rstd_no_pulse", tx_start_cnt, tx_snap);
    ena = 1'b1;
    bus.req_valid = 2'b11;
    xfer(0, 4'h1, 7'h0F);
    bus.req_valid = 2'b00;

    // Frame counter wrap
    rst_n = 1'b0; #2; rst_n = 1'b1;
    tick();
    bus.enc_code = 7'h01;
    repeat (255) fast_frame();
    chk("wrap_255", frame_count, 8'd255);
    fast_frame();
    chk("wrap_0", frame_count, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
